// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Raster-scan controller for the edge-detection pixel path. Counts the
//   column/row of each accepted pixel beat, gates the pixel register stage,
//   picks which of three rotating line buffers the beat is written into, and
//   flags when a full 3x3 neighbourhood is available for the Sobel window.
//   Each frame is framed by start / busy / frame_done.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   start        begin a frame (only honoured in IDLE)
//   in_valid     upstream pixel beat present
//   pix_en       in_valid qualified by RUN (combinational)
//   wr_line_sel  line buffer written by the current beat (0,1,2)
//   wr_addr      column address of the current beat
//   win_valid    registered: window centred at (win_row, win_col) complete
//   win_row      centre row of the window
//   win_col      centre column of the window
//   busy         controller not idle
//   frame_done   one-cycle pulse after the last pixel of a frame
//   overrun      sticky: a beat arrived while not in RUN
module frame_sequencer #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10,
    parameter int RW    = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          pix_en,
    output logic [1:0]    wr_line_sel,
    output logic [CW-1:0] wr_addr,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          frame_done,
    output logic          overrun
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    logic [1:0]    state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    line_sel;
    logic          accept;

    assign accept      = in_valid && (state == S_RUN);
    assign pix_en      = accept;
    assign wr_addr     = col;
    assign wr_line_sel = line_sel;
    assign busy        = (state != S_IDLE);
    // DONE lasts exactly one cycle, so the state itself is the pulse.
    assign frame_done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            line_sel  <= 2'd0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            overrun   <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A start clears overrun even if a stray beat arrives with it.
                    if (start) begin
                        state    <= S_RUN;
                        col      <= '0;
                        row      <= '0;
                        line_sel <= 2'd0;
                        overrun  <= 1'b0;
                    end else if (in_valid) begin
                        overrun <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        // The beat at (row, col) completes the window centred one up/left.
                        if (row >= ROW_MIN && col >= COL_MIN) begin
                            win_valid <= 1'b1;
                            win_row   <= row - RW'(1);
                            win_col   <= col - CW'(1);
                        end
                        if (col == COL_LAST) begin
                            // Last pixel: counters and line select hold into DONE.
                            if (row == ROW_LAST) begin
                                state <= S_DONE;
                            end else begin
                                col      <= '0;
                                row      <= row + RW'(1);
                                line_sel <= (line_sel == 2'd2) ? 2'd0 : line_sel + 2'd1;
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (in_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer
//   Drives a 4x3 and a 4x4 frame_sequencer from the same stimulus and compares
//   every output on every cycle against a frame model expressed as a running
//   count of accepted beats (column = k mod W, row = k div W).
module tb_frame_sequencer;

    localparam int CW = 3;
    localparam int RW = 3;

    logic clk = 1'b0;
    logic reset, start, in_valid;

    logic          pix_en      [2];
    logic [1:0]    wr_line_sel [2];
    logic [CW-1:0] wr_addr     [2];
    logic          win_valid   [2];
    logic [RW-1:0] win_row     [2];
    logic [CW-1:0] win_col     [2];
    logic          busy        [2];
    logic          frame_done  [2];
    logic          overrun     [2];

    always #5 clk = ~clk;

    frame_sequencer #(.IMG_W(4), .IMG_H(3), .CW(CW), .RW(RW)) u_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .pix_en(pix_en[0]), .wr_line_sel(wr_line_sel[0]), .wr_addr(wr_addr[0]),
        .win_valid(win_valid[0]), .win_row(win_row[0]), .win_col(win_col[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .overrun(overrun[0])
    );

    frame_sequencer #(.IMG_W(4), .IMG_H(4), .CW(CW), .RW(RW)) u_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .pix_en(pix_en[1]), .wr_line_sel(wr_line_sel[1]), .wr_addr(wr_addr[1]),
        .win_valid(win_valid[1]), .win_row(win_row[1]), .win_col(win_col[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .overrun(overrun[1])
    );

    int errors = 0;
    int checks = 0;

    // Reference model, one entry per instance.
    int W [2] = '{4, 4};
    int H [2] = '{3, 4};
    bit m_run [2];
    bit m_done[2];
    bit m_ov  [2];
    bit m_wv  [2];
    int m_k   [2];
    int m_wr  [2];
    int m_wc  [2];
    int win_count;

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d at %0t", tag, inst, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_done[i] = 0; m_ov[i] = 0; m_wv[i] = 0;
            m_k[i] = 0; m_wr[i] = 0; m_wc[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("pix_en",      i, 32'(pix_en[i]),      32'(in_valid && m_run[i]));
            chk("wr_line_sel", i, 32'(wr_line_sel[i]), 32'((m_k[i] / W[i]) % 3));
            chk("wr_addr",     i, 32'(wr_addr[i]),     32'(m_k[i] % W[i]));
            chk("win_valid",   i, 32'(win_valid[i]),   32'(m_wv[i]));
            chk("win_row",     i, 32'(win_row[i]),     32'(m_wr[i]));
            chk("win_col",     i, 32'(win_col[i]),     32'(m_wc[i]));
            chk("busy",        i, 32'(busy[i]),        32'(m_run[i] || m_done[i]));
            chk("frame_done",  i, 32'(frame_done[i]),  32'(m_done[i]));
            chk("overrun",     i, 32'(overrun[i]),     32'(m_ov[i]));
        end
        if (win_valid[0] === 1'b1) win_count++;
    endtask

    // Advance the model by one clock given the inputs applied this cycle.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_run[i] = 0; m_done[i] = 0; m_ov[i] = 0; m_wv[i] = 0;
                m_k[i] = 0; m_wr[i] = 0; m_wc[i] = 0;
            end else begin
                bit nwv;
                nwv = 0;
                if (m_run[i]) begin
                    if (in_valid) begin
                        int c, r;
                        c = m_k[i] % W[i];
                        r = m_k[i] / W[i];
                        if (r >= 2 && c >= 2) begin
                            nwv = 1; m_wr[i] = r - 1; m_wc[i] = c - 1;
                        end
                        if (m_k[i] == W[i] * H[i] - 1) begin
                            m_run[i] = 0; m_done[i] = 1;
                        end else begin
                            m_k[i]++;
                        end
                    end
                end else if (m_done[i]) begin
                    m_done[i] = 0;
                    if (in_valid) m_ov[i] = 1;
                end else begin
                    if (start) begin
                        m_run[i] = 1; m_k[i] = 0; m_ov[i] = 0;
                    end else if (in_valid) begin
                        m_ov[i] = 1;
                    end
                end
                m_wv[i] = nwv;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic v);
        @(negedge clk);
        reset = r; start = s; in_valid = v;
        #1;
        check_all();
        model_update();
    endtask

    task automatic steps(input int n, input logic s, input logic v);
        for (int j = 0; j < n; j++) step(1'b1, s, v);
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; in_valid = 1'b1;
        model_reset();
        win_count = 0;
        @(posedge clk);
        @(posedge clk);

        // Reset dominates start and in_valid.
        for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b1);
        steps(2, 1'b0, 1'b0);

        // Stray beat in IDLE sets overrun; start clears it.
        steps(1, 1'b0, 1'b1);
        steps(1, 1'b0, 1'b0);
        steps(1, 1'b1, 1'b0);

        // 12 contiguous beats: the 4x3 frame completes with two windows.
        win_count = 0;
        steps(12, 1'b0, 1'b1);
        steps(3, 1'b0, 1'b0);
        chk("win_count_4x3", 0, 32'(win_count), 32'((4 - 2) * (3 - 2)));

        // Finish the 4x4 frame; these beats are overruns for the 4x3 unit.
        steps(4, 1'b0, 1'b1);
        steps(3, 1'b0, 1'b0);

        // Alternating beats, with start repeatedly asserted during RUN.
        steps(1, 1'b1, 1'b0);
        for (int j = 0; j < 32; j++) step(1'b1, (j % 5) == 0, (j % 2) == 0);
        steps(4, 1'b0, 1'b0);

        // 16 contiguous beats: 4x4 line select wraps 0,1,2,0.
        steps(1, 1'b1, 1'b0);
        steps(16, 1'b0, 1'b1);
        steps(3, 1'b0, 1'b0);

        // Reset after beat 6 aborts, then a fresh frame runs to completion.
        steps(1, 1'b1, 1'b0);
        steps(6, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        steps(2, 1'b0, 1'b0);
        steps(1, 1'b1, 1'b0);
        steps(16, 1'b0, 1'b1);
        steps(3, 1'b0, 1'b0);

        // Randomised traffic, including occasional resets and starts.
        for (int j = 0; j < 400; j++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Raster-scan controller for the edge-detection pixel path. Tracks column/row position of each accepted pixel in a frame, gates the pixel register stage, steers writes into three rotating line buffers, and flags when a complete 3x3 neighbourhood is available to the Sobel window. It sits between the input pixel stream and the pixel stage / line buffers. It also frames each image with start, busy and done signalling.

## Interface
Parameters:
- IMG_W, 640, pixels per line (≥3)
- IMG_H, 480, lines per frame (≥3)
- CW, 10, column counter width (2^CW ≥ IMG_W)
- RW, 9, row counter width (2^RW ≥ IMG_H)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  begin a frame; sampled only in IDLE
- in_valid  input  1  upstream pixel beat present
- pix_en  output  1  combinational: in_valid && state==RUN; drives pixel stage in_valid
- wr_line_sel  output  2  line buffer written by current beat (0,1,2)
- wr_addr  output  CW  column address of current beat (= col)
- win_valid  output  1  registered: 3x3 window centred at (win_row, win_col) complete
- win_row  output  RW  centre row of window
- win_col  output  CW  centre column of window
- busy  output  1  state != IDLE
- frame_done  output  1  one-cycle pulse after last pixel of frame
- overrun  output  1  sticky: in_valid seen while not RUN

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → RUN next cycle; col, row, wr_line_sel cleared to 0; overrun cleared.
- RUN: each cycle with in_valid=1 is an accepted beat. wr_addr=col, wr_line_sel=current line at that cycle. On the clock edge:
  - col<IMG_W-1: col+1.
  - col==IMG_W-1: col←0, row+1, wr_line_sel rotates 0→1→2→0.
  - col==IMG_W-1 and row==IMG_H-1: state→DONE; counters hold.
- in_valid=0 in RUN: counters, line select, state hold.
- DONE: frame_done=1 for exactly this cycle; next state IDLE unconditionally.
- start in RUN or DONE: ignored.
- in_valid in IDLE or DONE: pix_en=0, beat dropped, overrun←1 (holds until next accepted start or reset).
- Window: at an accepted beat with row≥2 and col≥2, next cycle win_valid=1, win_row=row-1, win_col=col-1. Otherwise win_valid=0 next cycle; win_row/win_col hold their last values.
- Arithmetic: counters unsigned, compare against IMG_W-1/IMG_H-1 exactly; no wrap beyond these.

## Timing
- Reset (reset=0 at edge): state=IDLE, col=0, row=0, wr_line_sel=0, win_valid=0, win_row=0, win_col=0, frame_done=0, overrun=0. busy=0 and pix_en=0 follow.
- Reset mid-frame aborts immediately. No frame_done is issued. Next frame requires a new start.
- Reset has priority over start and in_valid in the same cycle.
- Latency: start→busy 1 cycle. Accepted beat→win_valid 1 cycle. Last beat→frame_done 1 cycle.
- frame_done cycle: busy=1. Following cycle busy=0. A start in that following cycle begins a new frame.
- Back-to-back beats: one pixel per clock sustained, no bubbles inserted.
- win_valid count per frame = (IMG_W-2)·(IMG_H-2).

## Test plan
- Reset: hold reset=0 with start=1, in_valid=1 → all outputs 0, state IDLE. Release: outputs stay 0 until start.
- IMG_W=4, IMG_H=3, start then 12 contiguous beats → win_valid high exactly twice, after beats 11 and 12, with (win_row,win_col)=(1,1),(1,2). wr_line_sel 0,0,0,0,1,1,1,1,2,2,2,2. frame_done one cycle after beat 12. busy low the cycle after that.
- Same frame with in_valid=0 on alternate cycles → identical sequence of win/line outputs, counters hold on idle cycles, frame_done after 12th accepted beat.
- IMG_W=4, IMG_H=4, 16 beats → line select wraps 0,1,2,0. 4 windows; last window centre (2,2).
- in_valid=1 in IDLE → pix_en=0, overrun=1 next cycle. start → overrun=0. start asserted during RUN → no counter reset.
- Reset asserted after beat 6 of a 12-beat frame → all outputs 0 next cycle, no frame_done. New start+12 beats completes normally.
